// File: rtl/timer_bus_pkg.sv
// Shared register map, STAT bit layout and per-timer flag record for timer_bus_ctrl.
package timer_bus_pkg;

  typedef enum logic [2:0] {
    OFS_CNT_L = 3'd0,
    OFS_CNT_H = 3'd1,
    OFS_RLD_L = 3'd2,
    OFS_RLD_H = 3'd3,
    OFS_CMP_L = 3'd4,
    OFS_CMP_H = 3'd5,
    OFS_CFG   = 3'd6,
    OFS_STAT  = 3'd7
  } reg_ofs_e;

  localparam int unsigned STAT_OVF    = 0;
  localparam int unsigned STAT_CMP    = 1;
  localparam int unsigned STAT_OVF_EN = 4;
  localparam int unsigned STAT_CMP_EN = 5;

  typedef struct packed {
    logic cmp_en;
    logic ovf_en;
    logic cmp;
    logic ovf;
  } tmr_flags_t;

  // Pack a flag record into the STAT read layout; unused bits read 0.
  function automatic logic [7:0] stat_byte(input tmr_flags_t f);
    logic [7:0] b;
    b              = '0;
    b[STAT_OVF]    = f.ovf;
    b[STAT_CMP]    = f.cmp;
    b[STAT_OVF_EN] = f.ovf_en;
    b[STAT_CMP_EN] = f.cmp_en;
    return b;
  endfunction

endpackage

// File: rtl/timer_bus_ctrl_flags.sv
// Per-timer sticky OVF/CMP flags with enables; event set beats W1C clear.
module timer_irq_flags
  import timer_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set_ovf,
  input  logic       i_set_cmp,
  input  logic       i_stat_we,
  input  logic [7:0] i_wdata,
  output tmr_flags_t o_flags,
  output logic       o_irq_req
);

  tmr_flags_t r_flags;
  logic       w_clr_ovf;
  logic       w_clr_cmp;

  assign w_clr_ovf = i_stat_we && i_wdata[STAT_OVF];
  assign w_clr_cmp = i_stat_we && i_wdata[STAT_CMP];

  // Flags: set pulse wins over a same-cycle clear; enables load on STAT write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      r_flags.ovf <= i_set_ovf || (r_flags.ovf && !w_clr_ovf);
      r_flags.cmp <= i_set_cmp || (r_flags.cmp && !w_clr_cmp);
      if (i_stat_we) begin
        r_flags.ovf_en <= i_wdata[STAT_OVF_EN];
        r_flags.cmp_en <= i_wdata[STAT_CMP_EN];
      end
    end
  end

  assign o_flags   = r_flags;
  assign o_irq_req = (r_flags.ovf && r_flags.ovf_en) || (r_flags.cmp && r_flags.cmp_en);

endmodule

// File: rtl/timer_bus_ctrl.sv
// Byte-wide CPU bus front end for NUM_TIMERS 16-bit timers: address decode,
// shared high-byte temp for atomic 16-bit access, read mux and merged irq.
module timer_bus_ctrl
  import timer_bus_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int AW = ((3 + $clog2(NUM_TIMERS)) < 4) ? 4 : (3 + $clog2(NUM_TIMERS))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sel,
  input  logic                    rd,
  input  logic                    wr,
  input  logic [AW-1:0]           addr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic                    irq,
  input  logic [16*NUM_TIMERS-1:0] t_counter_out,
  input  logic [16*NUM_TIMERS-1:0] t_reload_out,
  input  logic [16*NUM_TIMERS-1:0] t_compare_out,
  input  logic [8*NUM_TIMERS-1:0]  t_config_out,
  input  logic [NUM_TIMERS-1:0]    t_overflow_int,
  input  logic [NUM_TIMERS-1:0]    t_compare_int,
  output logic [16*NUM_TIMERS-1:0] t_counter_in,
  output logic [16*NUM_TIMERS-1:0] t_reload_in,
  output logic [16*NUM_TIMERS-1:0] t_compare_in,
  output logic [8*NUM_TIMERS-1:0]  t_config_in,
  output logic [2*NUM_TIMERS-1:0]  t_counter_write,
  output logic [2*NUM_TIMERS-1:0]  t_reload_write,
  output logic [2*NUM_TIMERS-1:0]  t_compare_write,
  output logic [NUM_TIMERS-1:0]    t_config_write
);

  localparam int unsigned NT = NUM_TIMERS;
  localparam int unsigned IW = AW - 3;

  logic [IW-1:0] w_idx;
  logic [31:0]   w_idx32;
  reg_ofs_e      w_ofs;
  logic          w_hit;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_hi;

  assign w_idx   = addr[AW-1:3];
  assign w_idx32 = 32'(w_idx);
  assign w_ofs   = reg_ofs_e'(addr[2:0]);
  assign w_hit   = sel && (w_idx32 < 32'(NUM_TIMERS));
  assign w_wr    = w_hit && wr;
  // A write in the same cycle suppresses the read; rdata then loads 0.
  assign w_rd    = w_hit && rd && !wr;
  assign w_wr_hi = w_wr && ((w_ofs == OFS_CNT_H) || (w_ofs == OFS_RLD_H) || (w_ofs == OFS_CMP_H));

  logic [7:0]              r_rdata;
  logic [7:0]              r_temp;
  logic                    r_irq;
  logic [16*NUM_TIMERS-1:0] r_cnt_in, r_rld_in, r_cmp_in;
  logic [8*NUM_TIMERS-1:0]  r_cfg_in;
  logic [2*NUM_TIMERS-1:0]  r_cnt_we, r_rld_we, r_cmp_we;
  logic [NUM_TIMERS-1:0]    r_cfg_we;

  tmr_flags_t            w_flags [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] w_irq_req;
  logic [NUM_TIMERS-1:0] w_stat_we;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_flags
    assign w_stat_we[g] = w_wr && (w_ofs == OFS_STAT) && (w_idx32 == 32'(g));
    timer_irq_flags u_flags (
      .clk       (clk),
      .reset     (reset),
      .i_set_ovf (t_overflow_int[g]),
      .i_set_cmp (t_compare_int[g]),
      .i_stat_we (w_stat_we[g]),
      .i_wdata   (wdata),
      .o_flags   (w_flags[g]),
      .o_irq_req (w_irq_req[g])
    );
  end

  logic [15:0] w_cnt, w_rld, w_cmp;
  logic [7:0]  w_cfg, w_stat, w_rdval;

  // Select the addressed timer's live values; out-of-range index yields zeros.
  always_comb begin
    w_cnt  = '0;
    w_rld  = '0;
    w_cmp  = '0;
    w_cfg  = '0;
    w_stat = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      if (w_idx32 == i) begin
        w_cnt  = t_counter_out[16*i +: 16];
        w_rld  = t_reload_out[16*i +: 16];
        w_cmp  = t_compare_out[16*i +: 16];
        w_cfg  = t_config_out[8*i +: 8];
        w_stat = stat_byte(w_flags[i]);
      end
    end
  end

  // Read data mux; CNT_H is served from temp so the 16-bit counter read is atomic.
  always_comb begin
    w_rdval = '0;
    if (w_rd) begin
      case (w_ofs)
        OFS_CNT_L: w_rdval = w_cnt[7:0];
        OFS_CNT_H: w_rdval = r_temp;
        OFS_RLD_L: w_rdval = w_rld[7:0];
        OFS_RLD_H: w_rdval = w_rld[15:8];
        OFS_CMP_L: w_rdval = w_cmp[7:0];
        OFS_CMP_H: w_rdval = w_cmp[15:8];
        OFS_CFG:   w_rdval = w_cfg;
        OFS_STAT:  w_rdval = w_stat;
        default:   w_rdval = '0;
      endcase
    end
  end

  // Registered read data, temp, timer write strobes/data and merged irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_temp   <= '0;
      r_irq    <= 1'b0;
      r_cnt_in <= '0;
      r_rld_in <= '0;
      r_cmp_in <= '0;
      r_cfg_in <= '0;
      r_cnt_we <= '0;
      r_rld_we <= '0;
      r_cmp_we <= '0;
      r_cfg_we <= '0;
    end else begin
      r_cnt_we <= '0;
      r_rld_we <= '0;
      r_cmp_we <= '0;
      r_cfg_we <= '0;
      r_irq    <= |w_irq_req;

      if (sel && rd) begin
        r_rdata <= w_rdval;
      end

      if (w_wr_hi) begin
        r_temp <= wdata;
      end else if (w_rd && (w_ofs == OFS_CNT_L)) begin
        r_temp <= w_cnt[15:8];
      end

      for (int unsigned i = 0; i < NT; i++) begin
        if (w_wr && (w_idx32 == i)) begin
          case (w_ofs)
            OFS_CNT_L: begin
              r_cnt_we[2*i +: 2]  <= 2'b11;
              r_cnt_in[16*i +: 16] <= {r_temp, wdata};
            end
            OFS_RLD_L: begin
              r_rld_we[2*i +: 2]  <= 2'b11;
              r_rld_in[16*i +: 16] <= {r_temp, wdata};
            end
            OFS_CMP_L: begin
              r_cmp_we[2*i +: 2]  <= 2'b11;
              r_cmp_in[16*i +: 16] <= {r_temp, wdata};
            end
            OFS_CFG: begin
              r_cfg_we[i]        <= 1'b1;
              r_cfg_in[8*i +: 8] <= wdata;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rdata           = r_rdata;
  assign irq             = r_irq;
  assign t_counter_in    = r_cnt_in;
  assign t_reload_in     = r_rld_in;
  assign t_compare_in    = r_cmp_in;
  assign t_config_in     = r_cfg_in;
  assign t_counter_write = r_cnt_we;
  assign t_reload_write  = r_rld_we;
  assign t_compare_write = r_cmp_we;
  assign t_config_write  = r_cfg_we;

endmodule

// File: tb/tb_timer_bus_ctrl.sv
// Scoreboard bench for timer_bus_ctrl: expectations are queued with a due cycle
// when stimulus is driven and compared once the DUT output is due.
module tb_timer_bus_ctrl;

  localparam int NT = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [7:0]      wdata = '0;
  logic [7:0]      rdata;
  logic            irq;
  logic [16*NT-1:0] t_counter_out = '0, t_reload_out = '0, t_compare_out = '0;
  logic [8*NT-1:0]  t_config_out = '0;
  logic [NT-1:0]    t_overflow_int = '0, t_compare_int = '0;
  logic [16*NT-1:0] t_counter_in, t_reload_in, t_compare_in;
  logic [8*NT-1:0]  t_config_in;
  logic [2*NT-1:0]  t_counter_write, t_reload_write, t_compare_write;
  logic [NT-1:0]    t_config_write;

  timer_bus_ctrl #(.NUM_TIMERS(NT), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .sel             (sel),
    .rd              (rd),
    .wr              (wr),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .irq             (irq),
    .t_counter_out   (t_counter_out),
    .t_reload_out    (t_reload_out),
    .t_compare_out   (t_compare_out),
    .t_config_out    (t_config_out),
    .t_overflow_int  (t_overflow_int),
    .t_compare_int   (t_compare_int),
    .t_counter_in    (t_counter_in),
    .t_reload_in     (t_reload_in),
    .t_compare_in    (t_compare_in),
    .t_config_in     (t_config_in),
    .t_counter_write (t_counter_write),
    .t_reload_write  (t_reload_write),
    .t_compare_write (t_compare_write),
    .t_config_write  (t_config_write)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RDATA, K_IRQ, K_STROBES, K_RLD1, K_CNT0, K_CMP0, K_CFG0} kind_e;
  typedef struct {
    int unsigned due;
    kind_e       kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RDATA:   return 32'(rdata);
      K_IRQ:     return 32'(irq);
      K_STROBES: return 32'({t_counter_write, t_reload_write, t_compare_write, t_config_write});
      K_RLD1:    return 32'({t_reload_write[3:2], t_reload_in[31:16]});
      K_CNT0:    return 32'({t_counter_write[1:0], t_counter_in[15:0]});
      K_CMP0:    return 32'({t_compare_write[1:0], t_compare_in[15:0]});
      K_CFG0:    return 32'({t_config_write[0], t_config_in[7:0]});
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input kind_e k, input logic [31:0] v, input string tag, input int unsigned lat);
    exp_t e;
    e.due  = cyc + lat;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Monitor: sample #1 after each rising edge and retire due expectations.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          check_eq(sb[i].tag, observe(sb[i].kind), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  task automatic bus(input logic s, input logic r, input logic w,
                     input logic [1:0] idx, input logic [2:0] ofs, input logic [7:0] d);
    @(posedge clk);
    #2;
    sel   = s;
    rd    = r;
    wr    = w;
    addr  = {idx, ofs};
    wdata = d;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00);
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [2:0] ofs, input logic [7:0] d);
    bus(1'b1, 1'b0, 1'b1, idx, ofs, d);
  endtask

  task automatic rd_reg(input logic [1:0] idx, input logic [2:0] ofs);
    bus(1'b1, 1'b1, 1'b0, idx, ofs, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    t_counter_out[15:0]  = 16'hABCD;
    t_reload_out[31:16]  = 16'hBEEF;
    t_compare_out[15:0]  = 16'h5A3C;
    t_config_out[15:8]   = 8'h7E;

    // Reset state
    idle();
    expect_at(K_RDATA,   32'h0, "reset_rdata", 1);
    expect_at(K_IRQ,     32'h0, "reset_irq", 1);
    expect_at(K_STROBES, 32'h0, "reset_strobes", 1);
    idle();
    reset = 1'b0;

    // Atomic reload write to timer 1
    wr_reg(2'd1, 3'd3, 8'h12);
    expect_at(K_STROBES, 32'h0, "no_strobe_on_H", 1);
    wr_reg(2'd1, 3'd2, 8'h34);
    expect_at(K_RLD1, 32'({2'b11, 16'h1234}), "rld1_write", 1);
    expect_at(K_STROBES, 32'({4'b0000, 4'b1100, 4'b0000, 2'b00}), "rld1_only_strobe", 1);
    idle();
    expect_at(K_STROBES, 32'h0, "strobe_single_cycle", 1);

    // Atomic counter read: high byte captured with the low byte
    rd_reg(2'd0, 3'd0);
    expect_at(K_RDATA, 32'hCD, "cnt_l_read", 1);
    rd_reg(2'd0, 3'd1);
    t_counter_out[15:0] = 16'hAC00;
    expect_at(K_RDATA, 32'hAB, "cnt_h_from_temp", 1);
    idle();
    expect_at(K_RDATA, 32'hAB, "rdata_hold", 1);

    // Live reads
    rd_reg(2'd1, 3'd3);
    expect_at(K_RDATA, 32'hBE, "rld_h_live", 1);
    rd_reg(2'd0, 3'd4);
    expect_at(K_RDATA, 32'h3C, "cmp_l_live", 1);
    rd_reg(2'd1, 3'd6);
    expect_at(K_RDATA, 32'h7E, "cfg_live", 1);

    // Temp captured by the CNT_L read feeds the next low-byte write
    wr_reg(2'd0, 3'd0, 8'h10);
    expect_at(K_CNT0, 32'({2'b11, 16'hAB10}), "cnt_write_uses_read_temp", 1);

    // Interrupt path
    wr_reg(2'd0, 3'd7, 8'h10);
    expect_at(K_IRQ, 32'h0, "irq_enable_only", 1);
    idle();
    t_overflow_int[0] = 1'b1;
    expect_at(K_IRQ, 32'h0, "irq_not_early", 1);
    expect_at(K_IRQ, 32'h1, "irq_rise", 2);
    idle();
    t_overflow_int[0] = 1'b0;
    rd_reg(2'd0, 3'd7);
    expect_at(K_RDATA, 32'h11, "stat_read", 1);
    idle();
    expect_at(K_IRQ, 32'h1, "stat_read_no_side_effect", 1);
    wr_reg(2'd0, 3'd7, 8'h11);
    expect_at(K_IRQ, 32'h1, "irq_before_drop", 1);
    expect_at(K_IRQ, 32'h0, "irq_drop", 2);
    idle();
    idle();
    wr_reg(2'd0, 3'd7, 8'h11);
    t_overflow_int[0] = 1'b1;
    expect_at(K_IRQ, 32'h1, "irq_set_wins", 2);
    idle();
    t_overflow_int[0] = 1'b0;
    rd_reg(2'd0, 3'd7);
    expect_at(K_RDATA, 32'h11, "stat_set_wins", 1);
    idle();
    t_compare_int[1] = 1'b1;
    idle();
    t_compare_int[1] = 1'b0;
    rd_reg(2'd1, 3'd7);
    expect_at(K_RDATA, 32'h02, "stat_cmp_flag_t1", 1);

    // Out-of-range timer index
    wr_reg(2'd0, 3'd1, 8'h42);
    wr_reg(2'd3, 3'd1, 8'h99);
    expect_at(K_STROBES, 32'h0, "oob_h_no_strobe", 1);
    wr_reg(2'd3, 3'd0, 8'h77);
    expect_at(K_STROBES, 32'h0, "oob_l_no_strobe", 1);
    wr_reg(2'd0, 3'd0, 8'h01);
    expect_at(K_CNT0, 32'({2'b11, 16'h4201}), "oob_temp_kept", 1);
    rd_reg(2'd3, 3'd4);
    expect_at(K_RDATA, 32'h0, "oob_read_zero", 1);

    // Simultaneous read and write
    rd_reg(2'd1, 3'd6);
    expect_at(K_RDATA, 32'h7E, "cfg1_read", 1);
    bus(1'b1, 1'b1, 1'b1, 2'd0, 3'd6, 8'h21);
    expect_at(K_CFG0, 32'({1'b1, 8'h21}), "rdwr_cfg_write", 1);
    expect_at(K_RDATA, 32'h0, "rdwr_rdata_zero", 1);
    idle();
    expect_at(K_CFG0, 32'({1'b0, 8'h21}), "cfg_strobe_single", 1);

    // Reset between high and low byte writes clears temp
    wr_reg(2'd0, 3'd5, 8'h55);
    idle();
    reset = 1'b1;
    expect_at(K_IRQ, 32'h0, "irq_reset", 1);
    idle();
    reset = 1'b0;
    wr_reg(2'd0, 3'd4, 8'h66);
    expect_at(K_CMP0, 32'({2'b11, 16'h0066}), "cmp_after_reset", 1);

    repeat (5) idle();
    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never observed (due cycle %0d)", sb[0].tag, sb[0].due);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_bus_ctrl.md
# timer_bus_ctrl

Memory-mapped controller between the 8-bit CPU I/O bus and `NUM_TIMERS` instances of the 16-bit `timer` block. It decodes byte accesses and drives each timer's byte-granular write strobes. A shared high-byte temp register makes 16-bit counter reads and counter/reload/compare writes atomic. It also holds per-timer sticky interrupt flags and enables, and merges them into one CPU interrupt line.

## Interface
- `NUM_TIMERS`, default 2: number of attached timers, range 1–32.
- `AW`, default `3+$clog2(NUM_TIMERS)` (minimum 4): bus address width.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `sel`  in  1  bus select for this block
- `rd`  in  1  read strobe, valid with `sel`
- `wr`  in  1  write strobe, valid with `sel`
- `addr`  in  AW  `addr[2:0]` is the register offset; `addr[AW-1:3]` is the timer index
- `wdata`  in  8  write data
- `rdata`  out  8  registered read data
- `irq`  out  1  level interrupt to the CPU
- `t_counter_out`, `t_reload_out`, `t_compare_out`  in  16*NUM_TIMERS  timer register values
- `t_config_out`  in  8*NUM_TIMERS  timer config
- `t_overflow_int`, `t_compare_int`  in  NUM_TIMERS  one-cycle event pulses from the timers
- `t_counter_in`, `t_reload_in`, `t_compare_in`  out  16*NUM_TIMERS  write data to the timers
- `t_config_in`  out  8*NUM_TIMERS  config write data
- `t_counter_write`, `t_reload_write`, `t_compare_write`  out  2*NUM_TIMERS  byte strobes, bit0 = low byte
- `t_config_write`  out  NUM_TIMERS  config strobe

## Operation
- Register offsets:
  - 0 CNT_L, 1 CNT_H
  - 2 RLD_L, 3 RLD_H
  - 4 CMP_L, 5 CMP_H
  - 6 CFG
  - 7 STAT: bit0 OVF flag, bit1 CMP flag, bit4 OVF enable, bit5 CMP enable, other bits read 0.
- A single `temp[7:0]` register is shared by all timers.
- Write to any `_H` offset: `temp <= wdata`. No timer strobe is issued.
- Write to CNT_L, RLD_L or CMP_L: the selected timer's matching strobe is `2'b11`, with data `{temp, wdata}`.
- Write to CFG: `t_config_write` is pulsed with `wdata`.
- Write to STAT:
  - Bits 1:0 are write-1-to-clear for the flags.
  - Bits 5:4 load the enables.
- Read CNT_L: returns `counter[7:0]` and captures `temp <= counter[15:8]` in the same cycle.
- Read CNT_H: returns `temp`.
- Read RLD_x, CMP_x, CFG: return the live timer values directly. `temp` is not involved.
- Read STAT: returns the flags and enables.
- Flags are sticky. `t_overflow_int[i]` sets OVF[i]; `t_compare_int[i]` sets CMP[i].
- `irq = |(flags & enables)` over all timers. It is registered.
- Boundary rules:
  - `rd` and `wr` in the same cycle: the write is performed, the read is ignored and `rdata <= 0`.
  - Timer index ≥ NUM_TIMERS: writes have no effect, including no `temp` update; reads return 0.
  - `sel` low: `rd` and `wr` are ignored.
  - Flag set pulse and W1C in the same cycle: set wins.
  - Read of STAT: has no side effects.

## Timing
- Reset: `rdata`, `temp`, all flags, all enables and `irq` are 0. All timer strobes are 0.
- All `t_*_in` and `t_*_write` outputs are registered. The strobe is high in cycle N+1 for a bus write in cycle N, so the timer register updates at the end of N+1. Strobes are single-cycle.
- Read latency is 1: `rdata` is valid in cycle N+1 for `rd` in cycle N and holds until the next read. The value is sampled from timer outputs in cycle N.
- A flag is set at the end of the pulse cycle. `irq` rises one cycle later.
- A clearing write in cycle N drops `irq` at the end of N+1.
- A `reset` asserted mid-sequence (e.g. between an `_H` and an `_L` write) clears `temp`. A following `_L` write then loads a high byte of 0x00.
- Back-to-back accesses every cycle are supported.

## Structure
- Package `timer_bus_pkg`:
  - offset constants `OFS_CNT_L`…`OFS_STAT`
  - STAT bit positions
  - `typedef struct packed` for per-timer flags and enables
- Sub-module `timer_irq_flags`, one instance per timer: holds the two flags and two enables, handles set/W1C priority, and outputs a per-timer irq request.
- The top level does the decode, the `temp` register, the read mux and the irq OR-reduce.

## Test plan
- Write RLD_H=0x12 then RLD_L=0x34 to timer 1:
  - `t_reload_write[3:2]=2'b11` and data 0x1234 appear exactly one cycle after the second write.
  - No strobe is issued after the first write.
- Timer 0 counter 0xABCD: read CNT_L, force the counter to 0xAC00, then read CNT_H.
  - `rdata` is 0xCD, then 0xAB.
- Set STAT enables=0x10 and pulse `t_overflow_int[0]`:
  - `irq` rises 2 cycles after the pulse.
  - Writing STAT=0x11 drops `irq`.
  - Pulse and W1C in the same cycle leaves OVF=1.
- Write to timer index 3 with NUM_TIMERS=2:
  - No strobes and no `temp` change.
  - A read returns 0x00.
- Simultaneous `rd`+`wr` to CFG with 0x21:
  - `t_config_write` pulses with 0x21.
  - `rdata` = 0x00.
- Write CMP_H=0x55, then `reset`, then CMP_L=0x66:
  - The compare data issued is 0x0066.
